// File: rtl/audio_event_scheduler.sv
// audio_event_scheduler
// Shares one tone player between the countdown-tick, goal and finish events.
// Single-cycle request pulses are latched as pending bits. The highest-priority
// pending event is granted the player. Each tone is timed and then followed by
// a silence gap. A finish request preempts any other tone that is playing.
module audio_event_scheduler #(
  parameter int unsigned TICK_DIV = 32'd100000,
  parameter int unsigned CNT_MS   = 32'd150,
  parameter int unsigned GOAL_MS  = 32'd300,
  parameter int unsigned END_MS   = 32'd1000,
  parameter int unsigned GAP_MS   = 32'd50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_cnt_i,
  input  logic       req_goal_i,
  input  logic       req_end_i,
  input  logic       cancel_i,
  input  logic       mute_i,
  output logic [1:0] tone_sel_o,
  output logic       tone_en_o,
  output logic       busy_o,
  output logic       grant_o,
  output logic [7:0] drop_cnt_o
);

  // Cycle lengths of each phase (products must fit in 32 bits)
  localparam logic [31:0] CNT_CYC  = CNT_MS  * TICK_DIV;
  localparam logic [31:0] GOAL_CYC = GOAL_MS * TICK_DIV;
  localparam logic [31:0] END_CYC  = END_MS  * TICK_DIV;
  localparam logic [31:0] GAP_CYC  = GAP_MS  * TICK_DIV;
  localparam logic [31:0] GAP_LAST = GAP_CYC - 32'd1;

  // Source encoding matches tone_sel; pending bit index is (source - 1)
  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_CNT  = 2'd1;
  localparam logic [1:0] SRC_GOAL = 2'd2;
  localparam logic [1:0] SRC_END  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // Fixed priority: end > goal > cnt
  function automatic logic [1:0] pick_src(input logic [2:0] pend);
    logic [1:0] src;
    if (pend[2]) begin
      src = SRC_END;
    end else if (pend[1]) begin
      src = SRC_GOAL;
    end else if (pend[0]) begin
      src = SRC_CNT;
    end else begin
      src = SRC_NONE;
    end
    return src;
  endfunction

  // Pending-bit mask for a source
  function automatic logic [2:0] src_mask(input logic [1:0] src);
    logic [2:0] mask;
    case (src)
      SRC_CNT:  mask = 3'b001;
      SRC_GOAL: mask = 3'b010;
      SRC_END:  mask = 3'b100;
      default:  mask = 3'b000;
    endcase
    return mask;
  endfunction

  // Tone length in clock cycles for a source
  function automatic logic [31:0] dur_of(input logic [1:0] src);
    logic [31:0] dur;
    case (src)
      SRC_CNT:  dur = CNT_CYC;
      SRC_GOAL: dur = GOAL_CYC;
      SRC_END:  dur = END_CYC;
      default:  dur = CNT_CYC;
    endcase
    return dur;
  endfunction

  // Number of set bits in a 3-bit mask
  function automatic logic [1:0] pop3(input logic [2:0] m);
    return {1'b0, m[0]} + {1'b0, m[1]} + {1'b0, m[2]};
  endfunction

  // Saturating add of up to three drops onto the 8-bit counter
  function automatic logic [7:0] sat_add(input logic [7:0] cnt, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, cnt} + {7'd0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  src_q, src_d;
  logic [31:0] timer_q, timer_d;
  logic [2:0]  pend_q, pend_d;
  logic [7:0]  drop_q, drop_d;
  logic [1:0]  tone_sel_q, tone_sel_d;
  logic        tone_en_q, tone_en_d;
  logic        grant_q, grant_d;

  logic        start_s;      // a source is granted the player at this edge
  logic [31:0] play_last_s;  // final timer value of the current tone
  logic [2:0]  req_s;
  logic [2:0]  clr_s;
  logic [2:0]  drop_hit_s;

  assign req_s       = {req_end_i, req_goal_i, req_cnt_i};
  assign play_last_s = dur_of(src_q) - 32'd1;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= SRC_NONE;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
    end
  end

  // FSM next state: grant from IDLE, finish preempts, timed PLAY/GAP exits, cancel wins
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    start_s = 1'b0;
    if (cancel_i) begin
      state_d = S_IDLE;
      src_d   = SRC_NONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pend_q != 3'b000) begin
            state_d = S_PLAY;
            src_d   = pick_src(pend_q);
            start_s = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_PLAY: begin
          if ((src_q != SRC_END) && pend_q[2]) begin
            // The preempted tone is abandoned; the finish tone starts afresh
            state_d = S_PLAY;
            src_d   = SRC_END;
            start_s = 1'b1;
          end else if (timer_q == play_last_s) begin
            state_d = S_GAP;
            src_d   = SRC_NONE;
          end else begin
            state_d = S_PLAY;
          end
        end
        S_GAP: begin
          // Pending requests are held here and only granted from IDLE
          if (timer_q == GAP_LAST) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
          end
        end
        default: begin
          state_d = S_IDLE;
          src_d   = SRC_NONE;
        end
      endcase
    end
  end

  // Pending bits, drop accounting and phase timer next values
  always_comb begin
    clr_s      = start_s ? src_mask(src_d) : 3'b000;
    // A request on its own grant edge re-arms the bit rather than being dropped
    drop_hit_s = req_s & pend_q & ~clr_s;
    if (cancel_i) begin
      pend_d = 3'b000;
      drop_d = drop_q;
    end else begin
      pend_d = (pend_q & ~clr_s) | req_s;
      drop_d = sat_add(drop_q, pop3(drop_hit_s));
    end
    if (start_s || (state_d != state_q) || (state_d == S_IDLE)) begin
      timer_d = 32'd0;
    end else begin
      timer_d = timer_q + 32'd1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= 3'b000;
      drop_q  <= 8'd0;
      timer_q <= 32'd0;
    end else begin
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      timer_q <= timer_d;
    end
  end

  // FSM outputs: tone select/enable follow the next state, grant marks a new tone
  always_comb begin
    if (state_d == S_PLAY) begin
      tone_sel_d = src_d;
      tone_en_d  = ~mute_i;
    end else begin
      tone_sel_d = SRC_NONE;
      tone_en_d  = 1'b0;
    end
    grant_d = start_s;
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tone_sel_q <= SRC_NONE;
      tone_en_q  <= 1'b0;
      grant_q    <= 1'b0;
    end else begin
      tone_sel_q <= tone_sel_d;
      tone_en_q  <= tone_en_d;
      grant_q    <= grant_d;
    end
  end

  assign tone_sel_o = tone_sel_q;
  assign tone_en_o  = tone_en_q;
  assign grant_o    = grant_q;
  assign busy_o     = (state_q != S_IDLE);
  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_audio_event_scheduler.sv
// Directed bench for audio_event_scheduler with a per-cycle expectation queue.
module tb_audio_event_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_cnt_i, req_goal_i, req_end_i, cancel_i, mute_i;
  logic [1:0] tone_sel_o;
  logic       tone_en_o, busy_o, grant_o;
  logic [7:0] drop_cnt_o;

  always #5 clk = ~clk;

  audio_event_scheduler #(
    .TICK_DIV(32'd2), .CNT_MS(32'd2), .GOAL_MS(32'd3), .END_MS(32'd5), .GAP_MS(32'd1)
  ) dut (
    .clk(clk), .rst(rst),
    .req_cnt_i(req_cnt_i), .req_goal_i(req_goal_i), .req_end_i(req_end_i),
    .cancel_i(cancel_i), .mute_i(mute_i),
    .tone_sel_o(tone_sel_o), .tone_en_o(tone_en_o), .busy_o(busy_o),
    .grant_o(grant_o), .drop_cnt_o(drop_cnt_o)
  );

  typedef struct packed {
    logic [1:0] sel;
    logic       en;
    logic       busy;
    logic       grant;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input int n, input logic [1:0] sel, input logic en,
                      input logic busy, input logic grant);
    obs_t e;
    e = {sel, en, busy, grant};
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic push_idle(input int n);
    push(n, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_tone(input logic [1:0] sel, input int n, input logic en);
    push(1, sel, en, 1'b1, 1'b1);
    push(n - 1, sel, en, 1'b1, 1'b0);
  endtask

  task automatic push_gap();
    push(2, 2'd0, 1'b0, 1'b1, 1'b0);
  endtask

  // One clock: drive inputs, take the edge, compare against the queue head
  task automatic tick(input logic [2:0] req, input logic cxl);
    obs_t obs;
    obs_t e;
    {req_end_i, req_goal_i, req_cnt_i} = req;
    cancel_i = cxl;
    @(posedge clk);
    #1;
    cyc++;
    obs = {tone_sel_o, tone_en_o, busy_o, grant_o};
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL underflow@%0d observed=%h expected=queued", cyc, obs);
    end else begin
      e = exp_q.pop_front();
      check8($sformatf("out@%0d(sel,en,busy,grant)", cyc), {3'b000, obs}, {3'b000, e});
    end
  endtask

  task automatic run_idle();
    while (exp_q.size() > 0) tick(3'b000, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    {req_cnt_i, req_goal_i, req_end_i, cancel_i, mute_i} = 5'b00000;

    // Reset state
    push_idle(2);
    tick(3'b000, 1'b0);
    tick(3'b000, 1'b0);
    check8("reset_drop", drop_cnt_o, 8'd0);
    rst = 1'b0;

    // 1: single goal pulse -> 6-cycle tone, 2-cycle gap, IDLE
    push_idle(1); push_tone(2'd2, 6, 1'b1); push_gap(); push_idle(1);
    tick(3'b010, 1'b0);
    run_idle();

    // 2: cnt and goal together -> goal first, then cnt
    push_idle(1); push_tone(2'd2, 6, 1'b1); push_gap(); push_idle(1);
    push_tone(2'd1, 4, 1'b1); push_gap(); push_idle(1);
    tick(3'b011, 1'b0);
    run_idle();
    check8("t2_drop", drop_cnt_o, 8'd0);

    // 3: three cnt pulses during a goal tone -> one cnt tone, two drops
    push_idle(1); push_tone(2'd2, 6, 1'b1); push_gap(); push_idle(1);
    push_tone(2'd1, 4, 1'b1); push_gap(); push_idle(1);
    tick(3'b010, 1'b0);
    tick(3'b000, 1'b0);
    tick(3'b001, 1'b0);
    tick(3'b001, 1'b0);
    tick(3'b001, 1'b0);
    run_idle();
    check8("t3_drop", drop_cnt_o, 8'd2);

    // 4: finish request two cycles into a cnt tone preempts it
    push_idle(1); push(1, 2'd1, 1'b1, 1'b1, 1'b1); push(2, 2'd1, 1'b1, 1'b1, 1'b0);
    push_tone(2'd3, 10, 1'b1); push_gap(); push_idle(4);
    tick(3'b001, 1'b0);
    tick(3'b000, 1'b0);
    tick(3'b000, 1'b0);
    tick(3'b100, 1'b0);
    run_idle();
    check8("t4_drop", drop_cnt_o, 8'd2);

    // 5: cancel in PLAY with goal pending; a same-edge finish request is discarded
    push_idle(1); push(1, 2'd1, 1'b1, 1'b1, 1'b1); push(1, 2'd1, 1'b1, 1'b1, 1'b0);
    push_idle(7);
    tick(3'b001, 1'b0);
    tick(3'b000, 1'b0);
    tick(3'b010, 1'b0);
    tick(3'b100, 1'b1);
    run_idle();
    check8("t5_drop", drop_cnt_o, 8'd2);

    // 6: held cnt request while muted -> drop saturates, tone_sel keeps sequencing
    mute_i = 1'b1;
    push_idle(1);
    for (int p = 0; p < 57; p++) begin
      push_tone(2'd1, 4, 1'b0); push_gap(); push_idle(1);
    end
    push(1, 2'd1, 1'b0, 1'b1, 1'b1);
    push(1, 2'd1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 402; i++) tick(3'b001, 1'b0);
    check8("t6_drop_sat", drop_cnt_o, 8'd255);

    // rst mid-tone clears everything including the drop counter
    rst = 1'b1;
    push_idle(1);
    tick(3'b000, 1'b0);
    rst = 1'b0;
    check8("t6_drop_rst", drop_cnt_o, 8'd0);
    push_idle(3);
    run_idle();
    mute_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
